// File: rtl/demux_pkg.sv
// Shared types and default sizing for the 1:16 sequential demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_pkg;

  // Default frame geometry; DEMUX_OUT_LENGTH must equal 2**DEMUX_SEL_LENGTH.
  localparam int DEMUX_OUT_LENGTH = 16;
  localparam int DEMUX_SEL_LENGTH = 4;

  // FILL: collecting bits. FULL: a finished frame waits in shadow for the output slot.
  typedef enum logic {FILL, FULL} demux_state_t;

endpackage

// File: rtl/demux_lane_tracker.sv
// Lane bookkeeping for the demux: picks the target lane, tracks written lanes, flags frame completion.
// Latency: lane/complete are combinational from the current beat; mask/counter/mode update at the edge.
// Backpressure: none of its own; it only advances on accept, which the top gates with in_ready.
//
// Ports:
//   clk, rstn   clock and synchronous active-low reset
//   accept      a bit is being taken this cycle
//   auto_en     requested mode, only honoured at frame start
//   sel         manual lane select
//   clr         frame handed off; clear the written-lane mask
//   lane        lane the current beat targets
//   lane_hot    one-hot form of lane
//   complete    this accept writes the last missing lane
module demux_lane_tracker
  import demux_pkg::*;
#(
  parameter int OUT_LENGTH = DEMUX_OUT_LENGTH,
  parameter int SEL_LENGTH = DEMUX_SEL_LENGTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  accept,
  input  logic                  auto_en,
  input  logic [SEL_LENGTH-1:0] sel,
  input  logic                  clr,
  output logic [SEL_LENGTH-1:0] lane,
  output logic [OUT_LENGTH-1:0] lane_hot,
  output logic                  complete
);

  logic [OUT_LENGTH-1:0] mask;
  logic [OUT_LENGTH-1:0] mask_set;
  logic [SEL_LENGTH-1:0] cnt;
  logic                  mode_auto;
  logic                  frame_start;
  logic                  use_auto;

  // An empty mask means no bit of the current frame has landed yet, so the
  // live auto_en decides the mode; afterwards the latched copy rules.
  assign frame_start = (mask == '0);
  assign use_auto    = frame_start ? auto_en : mode_auto;
  assign lane        = use_auto ? cnt : sel;
  assign lane_hot    = {{(OUT_LENGTH-1){1'b0}}, 1'b1} << lane;
  assign mask_set    = mask | lane_hot;
  // Completion counts distinct lanes, so a manual rewrite never finishes a frame early.
  assign complete    = accept && (&mask_set);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mask      <= '0;
      cnt       <= '0;
      mode_auto <= 1'b0;
    end else begin
      if (accept && frame_start) begin
        mode_auto <= auto_en;
      end
      // Counter wraps naturally at the top lane; a full auto frame leaves it at 0.
      if (accept && use_auto) begin
        cnt <= cnt + 1'b1;
      end
      if (clr) begin
        mask <= '0;
      end else if (accept) begin
        mask <= mask_set;
      end
    end
  end

endmodule

// File: rtl/demux_1x16_seq.sv
// Sequential 1:16 demux: assembles one bit per beat into a 16-lane frame and publishes it.
// Latency: last bit accepted at edge N -> out/out_valid updated at edge N (visible after N).
// Backpressure: in_ready drops only while a finished frame waits behind an unconsumed one.
//
// Ports:
//   clk, rstn                   clock and synchronous active-low reset
//   in_valid/in_ready/in_bit    input bit handshake
//   sel, auto_en                manual lane select / auto lane counter enable
//   out/out_valid/out_ready     published frame handshake
//   lane_strb                   registered one-hot of the lane written on the previous edge
//   out_parity                  XOR of out, only when built with DEMUX_PARITY_EN
module demux_1x16_seq
  import demux_pkg::*;
#(
  parameter int OUT_LENGTH = DEMUX_OUT_LENGTH,
  parameter int SEL_LENGTH = DEMUX_SEL_LENGTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_bit,
  input  logic [SEL_LENGTH-1:0] sel,
  input  logic                  auto_en,
  output logic [OUT_LENGTH-1:0] out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_LENGTH-1:0] lane_strb
`ifdef DEMUX_PARITY_EN
  ,output logic                 out_parity
`endif
);

  demux_state_t          state, state_next;
  logic [OUT_LENGTH-1:0] shadow, shadow_next;
  logic [SEL_LENGTH-1:0] lane;
  logic [OUT_LENGTH-1:0] lane_hot;
  logic                  accept;
  logic                  complete;
  logic                  publish;

  assign in_ready = (state == FILL);
  assign accept   = in_valid && in_ready;

  demux_lane_tracker #(
    .OUT_LENGTH(OUT_LENGTH),
    .SEL_LENGTH(SEL_LENGTH)
  ) u_tracker (
    .clk      (clk),
    .rstn     (rstn),
    .accept   (accept),
    .auto_en  (auto_en),
    .sel      (sel),
    .clr      (publish),
    .lane     (lane),
    .lane_hot (lane_hot),
    .complete (complete)
  );

  // Shadow including this beat's bit, so a completing beat publishes in the same edge.
  always_comb begin
    shadow_next = shadow;
    if (accept) begin
      shadow_next[lane] = in_bit;
    end
  end

  always_comb begin
    state_next = state;
    publish    = 1'b0;
    case (state)
      FILL: begin
        if (complete) begin
          if (!out_valid || out_ready) begin
            publish = 1'b1;
          end else begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        // out_valid is necessarily high here; the held shadow replaces it.
        if (out_ready) begin
          publish    = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= FILL;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      lane_strb <= '0;
    end else begin
      state     <= state_next;
      shadow    <= shadow_next;
      lane_strb <= accept ? lane_hot : '0;
      if (publish) begin
        out       <= shadow_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_parity <= 1'b0;
    end else if (publish) begin
      out_parity <= ^shadow_next;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x16_seq.sv
// Directed bench for demux_1x16_seq: auto/manual frames, lane rewrite, backpressure, reset, parity.
// Inputs change after the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_demux_1x16_seq;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_bit;
  logic [3:0]  sel;
  logic        auto_en;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] lane_strb;
`ifdef DEMUX_PARITY_EN
  logic        out_parity;
`endif

  int n_vec = 0;
  int n_err = 0;

  demux_1x16_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .sel       (sel),
    .auto_en   (auto_en),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lane_strb (lane_strb)
`ifdef DEMUX_PARITY_EN
    ,.out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One input beat; checks the strobe it produces.
  task automatic beat(input logic b, input logic [3:0] s, input logic [15:0] exp_strb, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = b;
    sel      = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_vec(tag, lane_strb, exp_strb);
  endtask

  // Sixteen auto beats carrying w lane by lane; out_valid checked just before the last beat.
  task automatic frame_auto(input logic [15:0] w, input logic vld_before, input string tag);
    logic [15:0] strb;
    for (int i = 0; i < 16; i++) begin
      strb = 16'h0001 << i;
      beat(w[i], 4'd0, strb, {tag, "_strb"});
      if (i == 14) check_vec({tag, "_vld_pre"}, out_valid, vld_before);
    end
  endtask

  task automatic idle_cycle;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0]  s;
    logic [15:0] strb;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sel       = 4'd0;
    auto_en   = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_vec("rst_out", out, 16'h0000);
    check_vec("rst_vld", out_valid, 1'b0);
    check_vec("rst_strb", lane_strb, 16'h0000);
    check_vec("rst_rdy", in_ready, 1'b1);
`ifdef DEMUX_PARITY_EN
    check_vec("rst_par", out_parity, 1'b0);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // 1: auto frame, consumer always ready
    auto_en = 1'b1;
    frame_auto(16'hD00B, 1'b0, "t1");
    check_vec("t1_out", out, 16'hD00B);
    check_vec("t1_vld", out_valid, 1'b1);
    idle_cycle();
    check_vec("t1_vld_drop", out_valid, 1'b0);
    check_vec("t1_out_hold", out, 16'hD00B);

    // 2: manual, lanes 15..0, ones on even lanes
    auto_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s    = 4'(15 - k);
      strb = 16'h0001 << s;
      beat(~s[0], s, strb, "t2_strb");
      if (k == 14) check_vec("t2_vld_pre", out_valid, 1'b0);
    end
    check_vec("t2_out", out, 16'h5555);
    check_vec("t2_vld", out_valid, 1'b1);
    idle_cycle();

    // 3: manual lane rewrite; mid-frame auto_en change must be ignored
    auto_en = 1'b0;
    beat(1'b1, 4'd3, 16'h0008, "t3_strb");
    auto_en = 1'b1;
    beat(1'b0, 4'd3, 16'h0008, "t3_strb_rw");
    for (int k = 0; k < 15; k++) begin
      s    = (k < 3) ? 4'(k) : 4'(k + 1);
      strb = 16'h0001 << s;
      beat(1'b1, s, strb, "t3_strb");
      if (k == 13) check_vec("t3_vld_at16", out_valid, 1'b0);
    end
    check_vec("t3_out", out, 16'hFFF7);
    check_vec("t3_vld", out_valid, 1'b1);
    idle_cycle();

    // 4: consumer stalled across two auto frames
    out_ready = 1'b0;
    auto_en   = 1'b1;
    frame_auto(16'h1234, 1'b0, "t4a");
    check_vec("t4a_out", out, 16'h1234);
    check_vec("t4a_vld", out_valid, 1'b1);
    check_vec("t4a_rdy", in_ready, 1'b1);
    frame_auto(16'hABCD, 1'b1, "t4b");
    check_vec("t4b_rdy", in_ready, 1'b0);
    check_vec("t4b_out_held", out, 16'h1234);
    check_vec("t4b_vld", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_vec("t4_full_strb", lane_strb, 16'h0000);
    check_vec("t4_full_rdy", in_ready, 1'b0);
    check_vec("t4_full_out", out, 16'h1234);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_vec("t4_pub_out", out, 16'hABCD);
    check_vec("t4_pub_vld", out_valid, 1'b1);
    check_vec("t4_pub_rdy", in_ready, 1'b1);
    idle_cycle();
    check_vec("t4_vld_drop", out_valid, 1'b0);
    check_vec("t4_out_hold", out, 16'hABCD);

    // 5: reset mid-frame, then a clean frame
    for (int i = 0; i < 7; i++) begin
      strb = 16'h0001 << i;
      beat(1'b1, 4'd0, strb, "t5_strb");
    end
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check_vec("t5_rst_out", out, 16'h0000);
    check_vec("t5_rst_vld", out_valid, 1'b0);
    check_vec("t5_rst_strb", lane_strb, 16'h0000);
    check_vec("t5_rst_rdy", in_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    frame_auto(16'h00F0, 1'b0, "t5");
    check_vec("t5_out", out, 16'h00F0);
    check_vec("t5_vld", out_valid, 1'b1);
    idle_cycle();

`ifdef DEMUX_PARITY_EN
    // 6: parity follows the published word
    frame_auto(16'h0007, 1'b0, "t6a");
    check_vec("t6a_out", out, 16'h0007);
    check_vec("t6a_par", out_parity, 1'b1);
    idle_cycle();
    frame_auto(16'h0003, 1'b0, "t6b");
    check_vec("t6b_out", out, 16'h0003);
    check_vec("t6b_par", out_parity, 1'b0);
    idle_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
